// File: rtl/exc_pkg.sv
// Shared encodings for the exception controller: FSM states and ESR syndrome codes.
package exc_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_HANDLER = 2'd1;
    localparam state_t ST_HALT    = 2'd2;

    localparam logic [3:0] ESR_IRQ    = 4'b0001;
    localparam logic [3:0] ESR_INVOP  = 4'b0010;
    localparam logic [3:0] ESR_DFAULT = 4'b1111;

endpackage

// File: rtl/exc_ctrl_irq_sync.sv
// Two-flop synchronizer for the external interrupt level; synchronous active-high reset.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: invalid-opcode/ERET/IRQ entry, ERET return, double-fault halt.
// Interrupt path (synchronizer + ExtIAck handshake) is built only with EXC_IRQ_EN defined.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter logic [63:0] VEC_ADDR = 64'hD8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC_in,
    input  logic        ExcInvOpcode,
    input  logic        ERet,
    input  logic        ExtIRQ,
    output logic        Exc,
    output logic        ERetTaken,
    output logic [63:0] ELR,
    output logic [3:0]  ESR,
    output logic        ExtIAck,
    output logic        InHandler,
    output logic        Halt
);

    // The datapath consumes the vector address; it is carried here so the exception contract sits in one place.
    localparam logic [63:0] UNUSED_VEC_ADDR = VEC_ADDR;

    state_t      r_state;
    logic [63:0] r_elr;
    logic [3:0]  r_esr;
    logic        w_irq_sync;
    logic        w_ack;
    logic        w_idle;
    logic        w_take_inv;
    logic        w_take_eret;
    logic        w_take_irq;
    logic        w_accept;
    logic        w_dfault;
    logic        w_ret;

`ifdef EXC_IRQ_EN
    logic r_ack;

    irq_sync u_irq_sync (
        .clk    (clk),
        .reset  (reset),
        .i_async(ExtIRQ),
        .o_sync (w_irq_sync)
    );

    // Acknowledge holds until the synchronized request is seen low, blocking re-entry even after ERET.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ack <= 1'b0;
        end else if (w_take_irq) begin
            r_ack <= 1'b1;
        end else if (!w_irq_sync) begin
            r_ack <= 1'b0;
        end
    end

    assign w_ack = r_ack;
`else
    logic w_unused_irq;

    assign w_unused_irq = ExtIRQ;
    assign w_irq_sync   = 1'b0;
    assign w_ack        = 1'b0;
`endif

    assign w_idle      = (r_state == ST_IDLE);
    assign w_take_inv  = w_idle && ExcInvOpcode;
    assign w_take_eret = w_idle && !ExcInvOpcode && ERet;
    assign w_take_irq  = w_idle && !ExcInvOpcode && !ERet && w_irq_sync && !w_ack && !reset;
    assign w_accept    = w_take_inv || w_take_eret || w_take_irq;
    assign w_dfault    = (r_state == ST_HANDLER) && ExcInvOpcode;
    assign w_ret       = (r_state == ST_HANDLER) && !ExcInvOpcode && ERet;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_elr   <= 64'd0;
            r_esr   <= 4'd0;
        end else if (w_accept) begin
            r_state <= ST_HANDLER;
            r_elr   <= PC_in;
            r_esr   <= w_take_irq ? ESR_IRQ : ESR_INVOP;
        end else if (w_dfault) begin
            r_state <= ST_HALT;
            r_esr   <= ESR_DFAULT;
        end else if (w_ret) begin
            r_state <= ST_IDLE;
        end
    end

    assign Exc       = !reset && w_accept;
    assign ERetTaken = !reset && w_ret;
    assign ELR       = r_elr;
    assign ESR       = r_esr;
    assign ExtIAck   = w_ack;
    assign InHandler = (r_state == ST_HANDLER);
    assign Halt      = (r_state == ST_HALT);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl; interrupt checks follow whether EXC_IRQ_EN is defined.
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] PC_in;
    logic        ExcInvOpcode;
    logic        ERet;
    logic        ExtIRQ;
    logic        Exc;
    logic        ERetTaken;
    logic [63:0] ELR;
    logic [3:0]  ESR;
    logic        ExtIAck;
    logic        InHandler;
    logic        Halt;

    int n_vec;
    int n_err;

    exc_ctrl #(.VEC_ADDR(64'hD8)) dut (
        .clk         (clk),
        .reset       (reset),
        .PC_in       (PC_in),
        .ExcInvOpcode(ExcInvOpcode),
        .ERet        (ERet),
        .ExtIRQ      (ExtIRQ),
        .Exc         (Exc),
        .ERetTaken   (ERetTaken),
        .ELR         (ELR),
        .ESR         (ESR),
        .ExtIAck     (ExtIAck),
        .InHandler   (InHandler),
        .Halt        (Halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b1;
        PC_in        = 64'd0;
        ExcInvOpcode = 1'b1;
        ERet         = 1'b0;
        ExtIRQ       = 1'b0;
        #1;
        chk("exc_in_reset", Exc, 1'b0);
        tick();
        tick();
        chk("rst_elr", ELR, 64'd0);
        chk("rst_esr", ESR, 4'd0);
        chk("rst_ack", ExtIAck, 1'b0);
        chk("rst_inh", InHandler, 1'b0);
        chk("rst_halt", Halt, 1'b0);
        reset = 1'b0;
        ExcInvOpcode = 1'b0;
        #1;
        chk("idle_no_exc", Exc, 1'b0);

        // Invalid opcode in IDLE
        PC_in = 64'h40; ExcInvOpcode = 1'b1; #1;
        chk("inv_exc", Exc, 1'b1);
        chk("inv_no_eret", ERetTaken, 1'b0);
        tick();
        ExcInvOpcode = 1'b0; #1;
        chk("inv_elr", ELR, 64'h40);
        chk("inv_esr", ESR, 4'b0010);
        chk("inv_inh", InHandler, 1'b1);
        chk("inh_no_exc", Exc, 1'b0);

        // ERET from handler
        PC_in = 64'h44; ERet = 1'b1; #1;
        chk("ret_taken", ERetTaken, 1'b1);
        chk("ret_no_exc", Exc, 1'b0);
        chk("ret_elr", ELR, 64'h40);
        tick();
        ERet = 1'b0; #1;
        chk("ret_inh", InHandler, 1'b0);
        chk("ret_esr", ESR, 4'b0010);

        // ERET while IDLE is an exception
        PC_in = 64'h8; ERet = 1'b1; #1;
        chk("eret_idle_exc", Exc, 1'b1);
        chk("eret_idle_noret", ERetTaken, 1'b0);
        tick();
        #1;
        chk("eret_idle_elr", ELR, 64'h8);
        chk("eret_idle_esr", ESR, 4'b0010);
        chk("eret_idle_ret", ERetTaken, 1'b1);
        tick();
        ERet = 1'b0; #1;
        chk("eret_idle_back", InHandler, 1'b0);

`ifdef EXC_IRQ_EN
        // IRQ: two-edge synchronizer latency
        PC_in = 64'h100; ExtIRQ = 1'b1;
        tick();
        chk("irq_e1_exc", Exc, 1'b0);
        tick();
        chk("irq_e2_exc", Exc, 1'b1);
        tick();
        chk("irq_elr", ELR, 64'h100);
        chk("irq_esr", ESR, 4'b0001);
        chk("irq_ack", ExtIAck, 1'b1);
        chk("irq_inh", InHandler, 1'b1);
        ERet = 1'b1;
        tick();
        ERet = 1'b0; #1;
        chk("irq_ack_blocks", Exc, 1'b0);
        ExtIRQ = 1'b0;
        tick();
        chk("ack_e1", ExtIAck, 1'b1);
        tick();
        chk("ack_e2", ExtIAck, 1'b1);
        tick();
        chk("ack_e3", ExtIAck, 1'b0);
        chk("ack_idle", InHandler, 1'b0);

        // Invalid opcode beats a simultaneous synchronized IRQ
        ExtIRQ = 1'b1;
        tick();
        tick();
        PC_in = 64'h200; ExcInvOpcode = 1'b1; #1;
        chk("both_exc", Exc, 1'b1);
        tick();
        ExcInvOpcode = 1'b0; #1;
        chk("both_esr", ESR, 4'b0010);
        chk("both_ack", ExtIAck, 1'b0);
        chk("both_elr", ELR, 64'h200);
        ERet = 1'b1; #1;
        chk("both_ret", ERetTaken, 1'b1);
        tick();
        ERet = 1'b0; PC_in = 64'h300; #1;
        chk("pend_exc", Exc, 1'b1);
        tick();
        chk("pend_esr", ESR, 4'b0001);
        chk("pend_ack", ExtIAck, 1'b1);
        chk("pend_elr", ELR, 64'h300);
        ExtIRQ = 1'b0; ERet = 1'b1;
        tick();
        ERet = 1'b0;
        tick();
        tick();
        chk("pend_ack_low", ExtIAck, 1'b0);
`else
        ExtIRQ = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("noirq_exc", Exc, 1'b0);
            chk("noirq_ack", ExtIAck, 1'b0);
        end
        ExtIRQ = 1'b0;
`endif

        // Double fault halts; ELR keeps the first fault PC
        PC_in = 64'h40; ExcInvOpcode = 1'b1;
        tick();
        PC_in = 64'h999; ERet = 1'b1; #1;
        chk("df_no_exc", Exc, 1'b0);
        chk("df_no_ret", ERetTaken, 1'b0);
        tick();
        ExcInvOpcode = 1'b0; ERet = 1'b0; #1;
        chk("df_halt", Halt, 1'b1);
        chk("df_esr", ESR, 4'b1111);
        chk("df_elr", ELR, 64'h40);
        chk("df_inh", InHandler, 1'b0);
        for (int i = 0; i < 10; i++) begin
            ExcInvOpcode = i[0];
            ERet         = ~i[0];
            tick();
            chk("halt_hold", Halt, 1'b1);
            chk("halt_exc", Exc, 1'b0);
            chk("halt_ret", ERetTaken, 1'b0);
            chk("halt_esr", ESR, 4'b1111);
            chk("halt_elr", ELR, 64'h40);
        end
        ExcInvOpcode = 1'b0; ERet = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        chk("halt_rst", Halt, 1'b0);
        chk("halt_rst_elr", ELR, 64'd0);
        chk("halt_rst_esr", ESR, 4'd0);

        // Reset mid-handler wins over ERET
        PC_in = 64'h60; ExcInvOpcode = 1'b1;
        tick();
        ExcInvOpcode = 1'b0; #1;
        chk("mid_inh", InHandler, 1'b1);
        reset = 1'b1; ERet = 1'b1; #1;
        chk("mid_rst_noret", ERetTaken, 1'b0);
        tick();
        reset = 1'b0; ERet = 1'b0; #1;
        chk("mid_rst_inh", InHandler, 1'b0);
        chk("mid_rst_elr", ELR, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 The block SHALL have parameter VEC_ADDR, default 64'hD8, which is the exception vector address the datapath loads into the PC when Exc=1.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 PC_in  input  64  PC of the instruction executing this cycle.
REQ-005 ExcInvOpcode  input  1  decoder flags the current instruction as invalid.
REQ-006 ERet  input  1  current instruction is ERET.
REQ-007 ExtIRQ  input  1  asynchronous level interrupt request.
REQ-008 Exc  output  1  combinational; exception accepted this cycle, so the datapath suppresses writes and loads VEC_ADDR into the PC.
REQ-009 ERetTaken  output  1  combinational; the datapath loads ELR into the PC this cycle.
REQ-010 ELR  output  64  exception link register.
REQ-011 ESR  output  4  exception syndrome register.
REQ-012 ExtIAck  output  1  registered interrupt acknowledge.
REQ-013 InHandler  output  1  high while state=HANDLER.
REQ-014 Halt  output  1  high while state=HALT.

Function
REQ-015 The FSM SHALL have states IDLE, HANDLER and HALT.
REQ-016 IDLE, priority order: ExcInvOpcode, then ERet, then the synchronized IRQ (only when ExtIAck=0).
- Any of these events: Exc=1.
- At the next edge: ELR<=PC_in and state<=HANDLER.
REQ-017 ESR codes: invalid opcode and ERet-in-IDLE SHALL give 4'b0010; IRQ SHALL give 4'b0001.
REQ-018 HANDLER:
- ExcInvOpcode=1: state<=HALT and ESR<=4'b1111; ELR unchanged; Exc=0.
- Otherwise ERet=1: ERetTaken=1 and state<=IDLE.
- ExtIRQ is ignored.
REQ-019 HALT SHALL persist until reset; Exc and ERetTaken SHALL be 0 in HALT.
REQ-020 ELR and ESR SHALL hold their values except on an accepted exception or a double fault.
REQ-021 Exc and ERetTaken SHALL never both be 1 in the same cycle.
REQ-022 ExtIRQ SHALL pass through a 2-flop synchronizer, giving a 2-edge latency before it is visible to the FSM.
REQ-023 ExtIAck handshake:
- ExtIAck SHALL rise at the edge that accepts an IRQ.
- ExtIAck SHALL fall at the edge after the synchronized IRQ is observed low.
- No new IRQ SHALL be accepted while ExtIAck=1, including after ERET.
REQ-024 An IRQ pending while state is HANDLER SHALL be taken in the first IDLE cycle after ERET.

Reset
REQ-025 On reset=1 at a rising edge, the block SHALL set state=IDLE, ELR=0, ESR=0, ExtIAck=0 and clear both synchronizer flops.
REQ-026 Reset SHALL take priority over every event, including reset asserted mid-HANDLER or in HALT.
REQ-027 Exc and ERetTaken SHALL be 0 in any cycle where reset=1.

Configuration
REQ-028 With macro EXC_IRQ_EN defined, the interrupt path (REQ-022 to REQ-024) SHALL be present.
REQ-029 Without EXC_IRQ_EN:
- The ExtIRQ port SHALL remain but be ignored.
- ExtIAck SHALL be tied to 0.
- The synchronizer SHALL not be instantiated.
- ESR=4'b0001 SHALL be unreachable.

Structure
REQ-030 Package exc_pkg SHALL hold the state enum and the ESR code constants (ESR_IRQ, ESR_INVOP, ESR_DFAULT).
REQ-031 The synchronizer SHALL be sub-module irq_sync (2-flop, synchronous reset).

Verification
REQ-032 PC_in=64'h40, ExcInvOpcode=1 for one cycle -> Exc=1 that cycle; next cycle ELR=64'h40, ESR=4'b0010, InHandler=1.
REQ-033 Continuing from REQ-032, ERet=1 -> ERetTaken=1 with ELR=64'h40 that cycle; next cycle InHandler=0 and ESR still 4'b0010.
REQ-034 EXC_IRQ_EN defined, ExtIRQ raised with PC_in=64'h100 -> Exc=1 after the 2nd edge; next edge gives ELR=64'h100, ESR=4'b0001, ExtIAck=1; drop ExtIRQ -> ExtIAck=0 on the 3rd edge after.
REQ-035 ExcInvOpcode and synchronized IRQ together in IDLE -> ESR=4'b0010 and ExtIAck=0; after ERET the IRQ is taken with ESR=4'b0001.
REQ-036 ExcInvOpcode while InHandler, ELR=64'h40 -> Halt=1, ESR=4'b1111, ELR=64'h40, holding for 10 cycles; reset -> Halt=0, ELR=0, ESR=0.
REQ-037 ERet=1 in IDLE with PC_in=64'h8 -> Exc=1; next cycle ELR=64'h8, ESR=4'b0010.
